fifo_uart_tx: RTL

- Downstream consumer of the 8-bit synchronous FIFO.
- Pops one byte at a time through the FIFO read port (rd_en / buf_empty / buf_out) and serialises it as an asynchronous UART frame on a single tx line.
- Sits between the FIFO and the board pin.
- Handles the FIFO's one-cycle read latency and paces pops so the FIFO is never read while a frame is in flight.

---
 rtl/fifo_uart_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pops bytes from a synchronous FIFO and sends each as a UART frame.
// Revision : 1.0
// ============================================================================
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              fifo_rd_en_q, fifo_rd_en_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    case (state_q)
      ST_IDLE: if (tx_enable && !fifo_empty) state_d = ST_POP;
      ST_POP:  state_d = ST_LOAD;
      ST_LOAD: begin
        // FIFO read data is valid exactly one cycle after the pop strobe
        shift_d  = fifo_data;
        parity_d = ^fifo_data;
        baud_d   = '0;
        bit_d    = '0;
        state_d  = ST_START;
      end
      ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
        if (!bit_end) begin
          baud_d = baud_q + BAUD_W'(1);
        end else begin
          baud_d = '0;
          if (state_q == ST_START) begin
            bit_d   = '0;
            state_d = ST_DATA;
          end else if (state_q == ST_DATA) begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              bit_d   = '0;
              state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
          end else if (state_q == ST_PARITY) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registers line up with state_q
  always_comb begin
    fifo_rd_en_d = (state_d == ST_POP);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      fifo_rd_en_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fifo_rd_en = fifo_rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
